// File: rtl/disk_dma_pkg.sv
// Shared types and constants for the disk <-> memory word copier.
package disk_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    WR,
    DONE,
    ERR
  } state_t;

  localparam logic [5:0] HALT_OP       = 6'b011000;
  localparam int         DISK_SIZE_DEF = 500;
  localparam logic       DIR_DISK2MEM  = 1'b0;
  localparam logic       DIR_MEM2DISK  = 1'b1;

endpackage

// File: rtl/disk_dma_addr_gen.sv
// Source/destination word pointers plus remaining and copied counters for one transfer.
module disk_dma_addr_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_src,
  input  logic [31:0] load_dst,
  input  logic [31:0] load_len,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [31:0] remaining,
  output logic [31:0] copied,
  output logic        last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      copied    <= '0;
    end else if (load) begin
      src       <= load_src;
      dst       <= load_dst;
      remaining <= load_len;
      copied    <= '0;
    end else if (step) begin
      src       <= src + 32'd1;
      dst       <= dst + 32'd1;
      remaining <= remaining - 32'd1;
      copied    <= copied + 32'd1;
    end
  end

  assign last = (remaining == 32'd1);

endmodule

// File: rtl/disk_dma.sv
// disk_dma: copies a block of words between the disk port and main memory, two cycles per word.
// Define DISK_DMA_HALT_STOP_EN to end disk->mem loads right after a word carrying HALT_OP.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   CHECK | disk-side range check, zero-length shortcut
//   RD    | source address on source port, read data captured at the edge
//   WR    | captured word written to destination for one cycle
//   DONE  | done pulse
//   ERR   | err pulse, nothing moved
module disk_dma #(
  parameter int         DATA_W    = 32,
  parameter int         DISK_SIZE = disk_dma_pkg::DISK_SIZE_DEF,
  parameter logic [5:0] HALT_OP   = disk_dma_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [31:0]       length,
  output logic [31:0]       disk_addr,
  output logic              disk_we,
  output logic [DATA_W-1:0] disk_wdata,
  input  logic [DATA_W-1:0] disk_rdata,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       words_copied
);
  import disk_dma_pkg::*;

`ifdef DISK_DMA_HALT_STOP_EN
  localparam logic HALT_STOP = 1'b1;
`else
  localparam logic HALT_STOP = 1'b0;
`endif

  state_t            state, state_nx;
  logic              dir_q;
  logic [DATA_W-1:0] data_buf;
  logic [31:0]       src, dst, remaining;
  logic              last, load, step;
  logic [31:0]       disk_base;
  logic [32:0]       range_end;
  logic              range_err, halt_hit;
  logic [31:0]       disk_addr_q, mem_addr_q;
  logic [DATA_W-1:0] disk_wdata_q, mem_wdata_q;

  assign load = (state == IDLE) && start;
  assign step = (state == WR);

  disk_dma_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .load_src  (src_addr),
    .load_dst  (dst_addr),
    .load_len  (length),
    .src       (src),
    .dst       (dst),
    .remaining (remaining),
    .copied    (words_copied),
    .last      (last)
  );

  // 33-bit sum so that a wrapping base+length is caught as out of range
  assign disk_base = (dir_q == DIR_DISK2MEM) ? src : dst;
  assign range_end = {1'b0, disk_base} + {1'b0, remaining};
  assign range_err = range_end > 33'(DISK_SIZE);
  assign halt_hit  = HALT_STOP && (dir_q == DIR_DISK2MEM) &&
                     (data_buf[DATA_W-1 -: 6] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dir_q        <= DIR_DISK2MEM;
      data_buf     <= '0;
      disk_addr_q  <= '0;
      mem_addr_q   <= '0;
      disk_wdata_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state        <= state_nx;
      disk_addr_q  <= disk_addr;
      mem_addr_q   <= mem_addr;
      disk_wdata_q <= disk_wdata;
      mem_wdata_q  <= mem_wdata;
      if (load) dir_q <= dir;
      if (state == RD) data_buf <= (dir_q == DIR_DISK2MEM) ? disk_rdata : mem_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: begin
        if (range_err)               state_nx = ERR;
        else if (remaining == 32'd0) state_nx = DONE;
        else                         state_nx = RD;
      end
      RD:    state_nx = WR;
      WR:    state_nx = (last || halt_hit) ? DONE : RD;
      DONE:  state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ports not being driven this cycle keep their previous address/data with we low
  always_comb begin
    disk_addr  = disk_addr_q;
    disk_wdata = disk_wdata_q;
    disk_we    = 1'b0;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_we     = 1'b0;
    if (state == RD) begin
      if (dir_q == DIR_DISK2MEM) disk_addr = src;
      else                       mem_addr  = src;
    end else if (state == WR) begin
      if (dir_q == DIR_DISK2MEM) begin
        mem_addr  = dst;
        mem_wdata = data_buf;
        mem_we    = 1'b1;
      end else begin
        disk_addr  = dst;
        disk_wdata = data_buf;
        disk_we    = 1'b1;
      end
    end
  end

  assign busy = (state == CHECK) || (state == RD) || (state == WR);
  assign done = (state == DONE);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_disk_dma.sv
// Self-checking bench for disk_dma: disk/memory models, a write scoreboard and directed transfers.
module tb_disk_dma;

  logic        clk = 1'b0;
  logic        reset, start, dir;
  logic [31:0] src_addr, dst_addr, length;
  logic [31:0] disk_addr, disk_wdata, disk_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        disk_we, mem_we, busy, done, err;
  logic [31:0] words_copied;

  always #5 clk = ~clk;

  disk_dma dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .disk_addr(disk_addr), .disk_we(disk_we), .disk_wdata(disk_wdata), .disk_rdata(disk_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .words_copied(words_copied)
  );

  logic [31:0] disk [0:511];
  logic [31:0] mem  [0:1023];

  assign disk_rdata = disk[disk_addr[8:0]];
  assign mem_rdata  = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (disk_we) disk[disk_addr[8:0]] = disk_wdata;
    if (mem_we)  mem[mem_addr[9:0]]   = mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          to_disk;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          exp_end;
  bit          exp_err;
  logic [31:0] exp_words;
  bit          mon_en = 1'b0;
  bit          prev_we = 1'b0;
  int          disk_we_cnt = 0;

  // Reference model: what the transfer must write, how many words, and when it ends
  task automatic predict(input logic d, input logic [31:0] s, input logic [31:0] ds,
                         input logic [31:0] n);
    logic [32:0] e;
    logic [31:0] base, a, data;
    int          k;
    wr_t         w;
    exp_q.delete();
    base = d ? ds : s;
    e = {1'b0, base} + {1'b0, n};
    if (e > 33'd500) begin
      exp_err = 1'b1; exp_words = 0; exp_end = 2;
      return;
    end
    exp_err = 1'b0;
    k = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + 32'(i);
      data = d ? mem[a[9:0]] : disk[a[8:0]];
      w.to_disk = d;
      w.addr = ds + 32'(i);
      w.data = data;
      exp_q.push_back(w);
      k++;
`ifdef DISK_DMA_HALT_STOP_EN
      if (!d && data[31:26] == 6'b011000) break;
`endif
    end
    exp_words = 32'(k);
    exp_end = (k == 0) ? 2 : 2 * k + 2;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_exclusive", {31'b0, disk_we & mem_we}, 32'd0);
      if (disk_we || mem_we) begin
        wr_t w;
        chk("we_single_cycle", {31'b0, prev_we}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_write", {31'b0, disk_we}, {31'b0, mem_we});
        else begin
          w = exp_q.pop_front();
          chk("wr_port", {31'b0, disk_we}, {31'b0, w.to_disk});
          chk("wr_addr", disk_we ? disk_addr : mem_addr, w.addr);
          chk("wr_data", disk_we ? disk_wdata : mem_wdata, w.data);
        end
        if (disk_we) disk_we_cnt++;
      end
      prev_we = disk_we | mem_we;
    end
  end

  int          last_cycle;
  logic [31:0] last_words;

  task automatic do_xfer(input logic d, input logic [31:0] s, input logic [31:0] ds,
                         input logic [31:0] n, input int poke_at);
    int cyc;
    bit fin;
    predict(d, s, ds, n);
    @(negedge clk);
    start = 1'b1; dir = d; src_addr = s; dst_addr = ds; length = n;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (done || err) fin = 1'b1;
      else begin
        chk("busy_during", {31'b0, busy}, 32'd1);
        if (cyc == poke_at) begin
          start = 1'b1; dir = ~d; src_addr = s + 32'd5; dst_addr = ds + 32'd7; length = n + 32'd3;
        end else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("finished", {31'b0, fin}, 32'd1);
    last_cycle = cyc;
    last_words = words_copied;
    chk("end_cycle", cyc, exp_end);
    chk("err_flag", {31'b0, err}, {31'b0, exp_err});
    chk("done_flag", {31'b0, done}, {31'b0, !exp_err});
    chk("words_copied", words_copied, exp_words);
    @(posedge clk); #1;
    chk("idle_after", {29'b0, busy, done, err}, 32'd0);
    chk("pending_writes", exp_q.size(), 32'd0);
  endtask

  int bad, nw, dw0;

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < 512; i++) disk[i] = 32'h0000_1000 + 32'(i) * 32'd3;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
    disk[53]  = 32'h6000_0000;
    disk[118] = 32'h6000_0077;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {disk_addr | disk_wdata | mem_addr | mem_wdata | words_copied},
        32'd0);
    chk("reset_flags", {27'b0, busy, done, err, disk_we, mem_we}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Program load ending on a halt word
    do_xfer(1'b0, 32'd0, 32'd0, 32'd54, 0);
    chk("load54_cycle", last_cycle, 32'd110);
    chk("load54_words", last_words, 32'd54);
    chk("load54_halt_word", mem[53], 32'h6000_0000);
    bad = 0;
    for (int i = 0; i < 54; i++) if (mem[i] !== disk[i]) bad++;
    chk("load54_image", bad, 32'd0);

    // Halt word in the middle of the requested block
    do_xfer(1'b0, 32'd64, 32'd0, 32'd64, 0);
`ifdef DISK_DMA_HALT_STOP_EN
    chk("halt_cycle", last_cycle, 32'd112);
    chk("halt_words", last_words, 32'd55);
    chk("halt_untouched", mem[55], 32'h5A5A_0037);
`else
    chk("nohalt_cycle", last_cycle, 32'd130);
    chk("nohalt_words", last_words, 32'd64);
    chk("nohalt_last", mem[63], disk[127]);
`endif

    // Memory to disk save
    mem[256] = 32'hA; mem[257] = 32'hB; mem[258] = 32'hC;
    dw0 = disk_we_cnt;
    do_xfer(1'b1, 32'h100, 32'd200, 32'd3, 0);
    chk("save_d200", disk[200], 32'hA);
    chk("save_d201", disk[201], 32'hB);
    chk("save_d202", disk[202], 32'hC);
    chk("save_we_count", disk_we_cnt - dw0, 32'd3);

    // Range errors and boundaries
    do_xfer(1'b0, 32'd498, 32'd0, 32'd3, 0);
    chk("err_cycle", last_cycle, 32'd2);
    chk("err_words", last_words, 32'd0);
    do_xfer(1'b0, 32'hFFFF_FFFF, 32'd0, 32'd2, 0);
    do_xfer(1'b1, 32'd0, 32'd499, 32'd2, 0);
    do_xfer(1'b0, 32'd497, 32'd600, 32'd3, 0);
    chk("edge_ok_cycle", last_cycle, 32'd8);
    do_xfer(1'b0, 32'd10, 32'd700, 32'd0, 0);
    chk("zero_cycle", last_cycle, 32'd2);

    // Second start mid-transfer is ignored
    do_xfer(1'b0, 32'd20, 32'd800, 32'd6, 4);
    chk("poke_words", last_words, 32'd6);
    bad = 0;
    for (int i = 0; i < 6; i++) if (mem[800 + i] !== disk[20 + i]) bad++;
    chk("poke_image", bad, 32'd0);

    // Reset after five words of a ten-word load
    predict(1'b0, 32'd300, 32'd500, 32'd10);
    @(negedge clk);
    start = 1'b1; dir = 1'b0; src_addr = 32'd300; dst_addr = 32'd500; length = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    nw = 0;
    for (int k = 0; k < 100 && nw < 5; k++) begin
      if (mem_we) nw++;
      if (nw < 5) begin @(posedge clk); #1; end
    end
    chk("reset_wait", nw, 32'd5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_we", {30'b0, disk_we, mem_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_words", words_copied, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++)
      chk("rst_mem_image", mem[500 + i], (i < 5) ? disk[300 + i] : 32'h5A5A_0000 + 32'(500 + i));
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disk_dma.md
# disk_dma

Word-granular transfer engine between the hard-disk model and main memory. It copies a block of `length` words either from disk to memory (program load into RAM) or from memory to disk (context/data save). It sits directly on the disk port, driving the disk's `addr`, `we` and `datain` and consuming its `dataout`. The CPU/OS layer starts a transfer with a one-cycle `start` pulse and waits for `done`.

## Interface
Parameters:
- `DATA_W`, 32: word width.
- `DISK_SIZE`, 500: number of disk words; used for range checking.
- `HALT_OP`, 6'b011000: opcode in `[31:26]` that marks the end of a program.

Ports:
- `clk` in 1: clock; disk and memory share this clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `dir` in 1: 0 = disk→mem, 1 = mem→disk; latched at `start`.
- `src_addr` in 32: first source word address; latched at `start`.
- `dst_addr` in 32: first destination word address; latched at `start`.
- `length` in 32: word count; latched at `start`.
- `disk_addr` out 32: to disk `addr`.
- `disk_we` out 1: to disk `we`.
- `disk_wdata` out 32: to disk `datain`.
- `disk_rdata` in 32: from disk `dataout`; valid before the posedge following address presentation.
- `mem_addr` out 32: memory word address.
- `mem_we` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; same 1-cycle timing as the disk.
- `busy` out 1: high from the cycle after an accepted `start` until DONE/ERR.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: one-cycle pulse on range error; no words are moved.
- `words_copied` out 32: words written by the last or current transfer.

## Operation
States and transitions:
- IDLE → CHECK on `start`.
- CHECK → ERR if the disk-side range (src for dir 0, dst for dir 1) satisfies `base + length > DISK_SIZE`. The comparison is 33-bit, so wrap counts as an error.
- CHECK → DONE if `length == 0`.
- CHECK → RD otherwise.
- RD: drive the source address on the source port with `we` low. At the posedge, latch the read data into `buf`.
- WR: drive the destination address, `wdata = buf`, `we = 1` for exactly one cycle. Then increment both addresses and `words_copied`, and decrement the remaining count.
- WR → DONE when the remaining count reaches 0; WR → RD otherwise.
- DONE: pulse `done` → IDLE.
- ERR: pulse `err` → IDLE.

Rules:
- Address arithmetic is modulo 2^32.
- `start` while not IDLE is ignored; latched operands are not disturbed.
- Unused port outputs hold their last address with `we = 0`. `disk_we` and `mem_we` are never high simultaneously.
- Reset mid-transfer: FSM returns to IDLE and every `we` drops on the next edge. Words already written stay written; `words_copied` is cleared.

## Timing
- Reset values: `busy` 0, `done` 0, `err` 0, `words_copied` 0, `disk_addr` 0, `disk_we` 0, `disk_wdata` 0, `mem_addr` 0, `mem_we` 0, `mem_wdata` 0.
- Throughput: 2 cycles per word (RD, WR).
- Latency for N ≥ 1 words: `done` asserts 2N+2 cycles after the `start` edge (CHECK + 2N + DONE).
- For N = 0, `done` asserts 2 cycles after `start`; ERR timing is identical.
- Next `start` is accepted the cycle after `done` or `err`.

## Configuration
- `DISK_DMA_HALT_STOP_EN` defined: in dir 0 only, a WR whose word has `[31:26] == HALT_OP` terminates the transfer after that write. The halt word is copied, and `words_copied` reflects the early stop. `length` still bounds the transfer and still drives the range check.
- Undefined: exactly `length` words are always copied; opcode is ignored.

## Structure
- Package `disk_dma_pkg`: state enum (IDLE, CHECK, RD, WR, DONE, ERR), `HALT_OP`, default `DISK_SIZE`, and `DIR_DISK2MEM`/`DIR_MEM2DISK` constants.
- One sub-module, `disk_dma_addr_gen`: loadable src/dst address registers plus remaining-count and copied-count counters, with load/step inputs and a `last` output. The top level holds the FSM, `buf` and the port muxing.

## Test plan
- Reset, then dir 0, src 0, dst 0, length 54 → `done` at cycle 110, memory[0..53] equals disk[0..53], memory[53] = 32'h6000_0000, `words_copied` 54.
- With HALT_STOP_EN: dir 0, src 64, dst 0, length 64 → stops after 55 words, `words_copied` 55, memory[55] untouched, `done` at cycle 112.
- Dir 1, src 0x100, dst 200, length 3 with memory 0xA/0xB/0xC → disk[200..202] = 0xA/0xB/0xC, `disk_we` high exactly 3 single cycles.
- Dir 0, src 498, length 3 → `err` pulse at cycle 2, no `we`, `words_copied` 0. Separately, length 0 → `done` at cycle 2.
- `start` pulsed again mid-transfer with different operands → ignored, original transfer completes unchanged.
- `reset` asserted after 5 words of a 10-word load → all `we` low next cycle, `busy` 0, `words_copied` 0. Memory words 0..4 are written and 5..9 unchanged.
